// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not served last.
// Purely combinational; never asserts both grants.
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_a,
  output logic gnt_b
);

  // last=1 means side b was served most recently
  assign gnt_a = req_a & (~req_b | last);
  assign gnt_b = req_b & (~req_a | ~last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one access in flight.
// Grant is same-cycle from request; response pulses MEM_LAT+1 cycles after grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_t        state;
  arb_owner_t        owner_q;
  arb_owner_t        last_q;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              half_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              pick_if;
  logic              pick_d;
  logic              can_arb;
  logic              grant;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^if_addr[1:0];

  rr_pick2 u_pick (
    .req_a (if_req),
    .req_b (d_req),
    .last  (last_q == OWN_D),
    .gnt_a (pick_if),
    .gnt_b (pick_d)
  );

  // Gated by reset so no grant leaks out while the block is held in reset
  assign can_arb = (state != ARB_BUSY) & reset;
  assign if_gnt  = can_arb & pick_if;
  assign d_gnt   = can_arb & pick_d;
  assign grant   = if_gnt | d_gnt;

  assign busy      = (state == ARB_BUSY);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = busy & we_q & (cnt == CNT_W'(MEM_LAT));
  assign if_rvalid = (state == ARB_RESP) & (owner_q == OWN_IF);
  assign d_rvalid  = (state == ARB_RESP) & (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      cnt        <= '0;
      we_q       <= 1'b0;
      half_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (grant) begin
      state   <= ARB_BUSY;
      cnt     <= CNT_W'(MEM_LAT);
      owner_q <= d_gnt ? OWN_D : OWN_IF;
      last_q  <= d_gnt ? OWN_D : OWN_IF;
      we_q    <= d_gnt & d_we;
      half_q  <= if_addr[2];
      if (d_gnt) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else begin
        addr_q <= {if_addr[ADDR_W-1:3], 3'b000};
      end
    end else if (state == ARB_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state <= ARB_RESP;
        if (owner_q == OWN_IF) begin
          if_rdata_q <= half_q ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
        end else begin
          d_rdata_q <= we_q ? '0 : mem_rdata;
        end
      end
    end else begin
      state <= ARB_IDLE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LAT=2 and a behavioural memory; directed scenarios
// followed by randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  logic        busy;

  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [63:0] poke_dat = '0;
  logic [63:0] mem [0:255];
  logic [63:0] ref_mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory: data for an address appears one edge later, so it is valid by the second cycle
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_dat;
    else if (mem_wr) mem[mem_addr[10:3]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[10:3]];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, limit 400000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic init_mem();
    logic [63:0] v;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = {$urandom, $urandom};
      if (i == 32) v = 64'hAAAA_BBBB_1111_2222;
      poke_en = 1'b1; poke_idx = 8'(i); poke_dat = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] zero_gnt;
    logic seen;
    zero_gnt = 2'b00;
    @(negedge clk); #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_wr, busy} !== '0)
      $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b busy=%b wr=%b addr=%h required all zero",
               if_gnt, d_gnt, if_rvalid, d_rvalid, busy, mem_wr, mem_addr);
    if ({if_gnt, d_gnt} !== zero_gnt) errors++;
    else if ({if_rvalid, if_rdata, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_wr, busy} !== '0) errors++;
    // load granted, then reset pulled while it is in flight
    reset = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40; #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL reset_first_gnt: d_gnt=%b required 1", d_gnt);
    end
    @(negedge clk);
    d_req = 1'b0; #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_before: busy=%b required 1", busy);
    end
    reset = 1'b0; #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_wdata, mem_wr, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b rv=%b%b addr=%h required all zero", busy, if_rvalid, d_rvalid, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (d_rvalid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_dropped: stale d_rvalid/busy seen=%b required 0", seen);
    end
  endtask

  task automatic test_fetch(input logic [63:0] addr, input logic [31:0] exp);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr; #1;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt: gnt(if,d)=%b%b required 10", if_gnt, d_gnt);
    end
    @(negedge clk);
    if_req = 1'b0; #1;
    checks++;
    if (busy !== 1'b1 || mem_addr !== {addr[63:3], 3'b000}) begin
      errors++; $display("FAIL fetch_addr: busy=%b mem_addr=%h required 1 %h", busy, mem_addr, {addr[63:3], 3'b000});
    end
    @(negedge clk); #1;
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_early: if_rvalid=%b at T+2 required 0", if_rvalid);
    end
    @(negedge clk); #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== exp) begin
      errors++; $display("FAIL fetch_data: rvalid=%b rdata=%h required 1 %h", if_rvalid, if_rdata, exp);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] wd;
    wd = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = wd; #1;
    checks++;
    if (d_gnt !== 1'b1 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL store_gnt: d_gnt=%b mem_wr=%b required 1 0", d_gnt, mem_wr);
    end
    ref_mem[8] = wd;
    @(negedge clk);
    d_req = 1'b0; #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 64'h40 || mem_wdata !== wd) begin
      errors++; $display("FAIL store_write: wr=%b addr=%h data=%h required 1 40 %h", mem_wr, mem_addr, mem_wdata, wd);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_wr !== 1'b0) begin
      errors++; $display("FAIL store_wr_once: mem_wr=%b at T+2 required 0", mem_wr);
    end
    @(negedge clk); #1;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 64'h0) begin
      errors++; $display("FAIL store_resp: rvalid=%b rdata=%h required 1 0", d_rvalid, d_rdata);
    end
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL load_gnt: d_gnt=%b required 1", d_gnt);
    end
    @(negedge clk);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== wd) begin
      errors++; $display("FAIL load_after_store: rvalid=%b rdata=%h required 1 %h", d_rvalid, d_rdata, wd);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    reset = 1'b0;
    if_addr = 64'h100; d_addr = 64'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      errors++; $display("FAIL alt_in_reset: gnt(if,d)=%b%b required 00", if_gnt, d_gnt);
    end
    @(negedge clk);
    reset = 1'b1; #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      exp = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      checks++;
      if ({if_gnt, d_gnt} !== exp) begin
        errors++; $display("FAIL alt_cycle%0d: gnt(if,d)=%b%b required %b", k, if_gnt, d_gnt, exp);
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_g, exp_v;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) d_req = 1'b0;
      #1;
      exp_g = (k == 0 || k == 3);
      exp_v = (k == 3 || k == 6);
      checks++;
      if (d_gnt !== exp_g || d_rvalid !== exp_v || (busy & (if_gnt | d_gnt)) !== 1'b0) begin
        errors++; $display("FAIL b2b_cycle%0d: gnt=%b rvalid=%b busy=%b required %b %b", k, d_gnt, d_rvalid, busy, exp_g, exp_v);
      end
    end
    checks++;
    if (d_rdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL b2b_data: d_rdata=%h required 0123456789abcdef", d_rdata);
    end
  endtask

  task automatic test_random();
    int next_ok, gc, resp_cyc;
    logic last_d, gstore, resp_d, if_pend, d_pend;
    logic exp_if, exp_d, exp_busy, exp_wr, exp_ifv, exp_dv;
    logic [63:0] resp_dat, word;
    next_ok = 0; gc = -10; resp_cyc = -1;
    last_d = 1'b0; gstore = 1'b0; resp_d = 1'b0; if_pend = 1'b0; d_pend = 1'b0;
    resp_dat = '0;
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1; if_addr = 64'($urandom_range(0, 511)) << 2;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 64'($urandom_range(0, 15)) << 3; d_wdata = {$urandom, $urandom};
      end
      if_req = if_pend; d_req = d_pend;
      #1;
      exp_if = 1'b0; exp_d = 1'b0;
      if (cyc >= next_ok) begin
        if (if_pend && d_pend) begin
          exp_if = last_d; exp_d = !last_d;
        end else begin
          exp_if = if_pend; exp_d = d_pend;
        end
      end
      exp_busy = (cyc > gc) && (cyc <= gc + 2);
      exp_wr   = (cyc == gc + 1) && gstore;
      exp_ifv  = (cyc == resp_cyc) && !resp_d;
      exp_dv   = (cyc == resp_cyc) && resp_d;
      checks++;
      if ({if_gnt, d_gnt, busy, mem_wr, if_rvalid, d_rvalid} !== {exp_if, exp_d, exp_busy, exp_wr, exp_ifv, exp_dv}) begin
        errors++;
        $display("FAIL rand_ctl c%0d: gnt=%b%b busy=%b wr=%b rv=%b%b required %b%b %b %b %b%b", cyc,
                 if_gnt, d_gnt, busy, mem_wr, if_rvalid, d_rvalid, exp_if, exp_d, exp_busy, exp_wr, exp_ifv, exp_dv);
      end
      if (exp_ifv) begin
        checks++;
        if (if_rdata !== resp_dat[31:0]) begin
          errors++; $display("FAIL rand_if_data c%0d: got %h required %h", cyc, if_rdata, resp_dat[31:0]);
        end
      end
      if (exp_dv) begin
        checks++;
        if (d_rdata !== resp_dat) begin
          errors++; $display("FAIL rand_d_data c%0d: got %h required %h", cyc, d_rdata, resp_dat);
        end
      end
      if (exp_if || exp_d) begin
        gc = cyc; next_ok = cyc + 3; resp_cyc = cyc + 3;
        if (exp_if) begin
          word = ref_mem[if_addr[10:3]];
          resp_dat = {32'h0, if_addr[2] ? word[63:32] : word[31:0]};
          resp_d = 1'b0; gstore = 1'b0; last_d = 1'b0; if_pend = 1'b0;
        end else begin
          resp_d = 1'b1; gstore = d_we; last_d = 1'b1; d_pend = 1'b0;
          if (d_we) begin
            resp_dat = '0; ref_mem[d_addr[10:3]] = d_wdata;
          end else begin
            resp_dat = ref_mem[d_addr[10:3]];
          end
        end
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    init_mem();
    test_reset();
    test_fetch(64'h104, 32'hAAAA_BBBB);
    test_fetch(64'h100, 32'h1111_2222);
    test_store_load();
    test_alternate();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
